// File: rtl/duty_ramp_ctrl.sv
// rtl/duty_ramp_ctrl.sv - PWM duty ramp controller stepping the compare value toward a target every N periods
// Optional build macro: DUTY_CLAMP_EN clamps captured targets to MAX_DUTY.
module duty_ramp_ctrl #(
    parameter int WIDTH            = 7,
    parameter int STEP             = 1,
    parameter int PERIODS_PER_STEP = 1,
    parameter int MAX_DUTY         = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             period_end,
    input  logic             enable,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] ccr_val,
    output logic             ccr_load,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;

    localparam int unsigned      FULL       = (1 << WIDTH) - 1;
    localparam int unsigned      STEP_CLIP  = (STEP > FULL) ? FULL : STEP;
    localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP_CLIP);
    localparam logic [7:0]       PRESC_LAST = 8'(PERIODS_PER_STEP - 1);

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [7:0]       presc;
    logic [WIDTH-1:0] eff_target;
    logic [WIDTH-1:0] cap_data;
    logic [WIDTH-1:0] gap;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] step_val;
    logic             rising;
    logic             capture;

    assign tgt_ready  = enable && (state == IDLE || state == HOLD);
    assign capture    = tgt_valid && tgt_ready;
    assign busy       = (state == UP) || (state == DOWN);
    assign eff_target = enable ? target : '0;

    // Step size is limited by the remaining distance so the ramp lands exactly on target.
    assign rising   = eff_target > ccr_val;
    assign gap      = rising ? (eff_target - ccr_val) : (ccr_val - eff_target);
    assign delta    = (gap > STEP_V) ? STEP_V : gap;
    assign step_val = rising ? (ccr_val + delta) : (ccr_val - delta);

`ifdef DUTY_CLAMP_EN
    localparam int unsigned      MAX_CLIP = (MAX_DUTY > FULL) ? FULL : MAX_DUTY;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_CLIP);
    assign cap_data = (tgt_data > MAX_V) ? MAX_V : tgt_data;
`else
    assign cap_data = tgt_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ccr_val  <= '0;
            target   <= '0;
            presc    <= '0;
            ccr_load <= 1'b0;
            done     <= 1'b0;
        end else begin
            ccr_load <= 1'b0;
            done     <= 1'b0;
            if (capture) begin
                target <= cap_data;
                presc  <= '0;
                if (cap_data > ccr_val) begin
                    state <= UP;
                end else if (cap_data < ccr_val) begin
                    state <= DOWN;
                end else begin
                    state <= HOLD;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE, HOLD: begin
                        if (eff_target > ccr_val) begin
                            state <= UP;
                        end else if (eff_target < ccr_val) begin
                            state <= DOWN;
                        end else if (!enable) begin
                            state <= IDLE;
                        end
                    end
                    UP, DOWN: begin
                        if (eff_target == ccr_val) begin
                            // Target moved onto the current value (enable edge); settle without a step.
                            state <= (eff_target == '0) ? IDLE : HOLD;
                        end else begin
                            state <= rising ? UP : DOWN;
                            if (period_end) begin
                                if (presc == PRESC_LAST) begin
                                    presc    <= '0;
                                    ccr_val  <= step_val;
                                    ccr_load <= 1'b1;
                                    if (step_val == eff_target) begin
                                        state <= (eff_target == '0) ? IDLE : HOLD;
                                        done  <= 1'b1;
                                    end
                                end else begin
                                    presc <= presc + 8'd1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// tb/tb_duty_ramp_ctrl.sv - directed self-checking bench for duty_ramp_ctrl
module tb_duty_ramp_ctrl;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         period_end = 1'b0;
    logic         enable = 1'b0;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_data = '0;

    logic         a_ready, a_load, a_busy, a_done;
    logic [W-1:0] a_ccr;
    logic         b_ready, b_load, b_busy, b_done;
    logic [W-1:0] b_ccr;
    logic         c_ready, c_load, c_busy, c_done;
    logic [W-1:0] c_ccr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    duty_ramp_ctrl #(.WIDTH(W), .STEP(1), .PERIODS_PER_STEP(2), .MAX_DUTY(100)) u_a (
        .clk(clk), .rst_n(rst_n), .period_end(period_end), .enable(enable),
        .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(a_ready),
        .ccr_val(a_ccr), .ccr_load(a_load), .busy(a_busy), .done(a_done));

    duty_ramp_ctrl #(.WIDTH(W), .STEP(4), .PERIODS_PER_STEP(1), .MAX_DUTY(100)) u_b (
        .clk(clk), .rst_n(rst_n), .period_end(period_end), .enable(enable),
        .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(b_ready),
        .ccr_val(b_ccr), .ccr_load(b_load), .busy(b_busy), .done(b_done));

    duty_ramp_ctrl #(.WIDTH(W), .STEP(8), .PERIODS_PER_STEP(1), .MAX_DUTY(100)) u_c (
        .clk(clk), .rst_n(rst_n), .period_end(period_end), .enable(enable),
        .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(c_ready),
        .ccr_val(c_ccr), .ccr_load(c_load), .busy(c_busy), .done(c_done));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pe();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic offer(input logic [W-1:0] v);
        tgt_valid = 1'b1;
        tgt_data  = v;
        tick();
        tgt_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b1;
        tgt_valid  = 1'b0;
        period_end = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        enable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_ccr !== 0 || b_ccr !== 0 || c_ccr !== 0) begin
            failures++;
            $display("FAIL reset_ccr got a=%0d b=%0d c=%0d expected 0", a_ccr, b_ccr, c_ccr);
        end
        checks++;
        if ({a_busy, b_busy, c_busy, a_load, b_load, c_load, a_done, b_done, c_done} !== 9'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b%b%b load=%b%b%b done=%b%b%b expected all 0",
                     a_busy, b_busy, c_busy, a_load, b_load, c_load, a_done, b_done, c_done);
        end
        checks++;
        if ({a_ready, b_ready, c_ready} !== 3'b111) begin
            failures++;
            $display("FAIL reset_ready got %b%b%b expected 111", a_ready, b_ready, c_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (a_ccr !== 0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got ccr=%0d busy=%b ready=%b expected 0 0 1", a_ccr, a_busy, a_ready);
        end
    endtask

    task automatic test_ramp_up();
        do_reset();
        offer(5);
        checks++;
        if (a_busy !== 1'b1 || a_ccr !== 0) begin
            failures++;
            $display("FAIL ramp_start got busy=%b ccr=%0d expected 1 0", a_busy, a_ccr);
        end
        for (int k = 1; k <= 5; k++) begin
            pe();
            checks++;
            if (a_load !== 1'b0 || a_ccr !== W'(k - 1)) begin
                failures++;
                $display("FAIL ramp_odd_pe k=%0d got load=%b ccr=%0d expected 0 %0d", k, a_load, a_ccr, k - 1);
            end
            pe();
            checks++;
            if (a_load !== 1'b1 || a_ccr !== W'(k) || a_done !== (k == 5)) begin
                failures++;
                $display("FAIL ramp_step k=%0d got load=%b ccr=%0d done=%b expected 1 %0d %b",
                         k, a_load, a_ccr, a_done, k, (k == 5));
            end
        end
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_ready !== 1'b1 || a_ccr !== 5) begin
            failures++;
            $display("FAIL ramp_hold got busy=%b done=%b ready=%b ccr=%0d expected 0 0 1 5",
                     a_busy, a_done, a_ready, a_ccr);
        end
        pe();
        pe();
        checks++;
        if (a_load !== 1'b0 || a_ccr !== 5) begin
            failures++;
            $display("FAIL hold_ignores_pe got load=%b ccr=%0d expected 0 5", a_load, a_ccr);
        end
    endtask

    task automatic test_no_overshoot();
        int up_seq [3];
        int dn_seq [2];
        up_seq = '{4, 8, 10};
        dn_seq = '{6, 3};
        do_reset();
        offer(10);
        for (int i = 0; i < 3; i++) begin
            pe();
            checks++;
            if (b_load !== 1'b1 || b_ccr !== W'(up_seq[i]) || b_done !== (i == 2)) begin
                failures++;
                $display("FAIL overshoot_up i=%0d got load=%b ccr=%0d done=%b expected 1 %0d %b",
                         i, b_load, b_ccr, b_done, up_seq[i], (i == 2));
            end
        end
        tick();
        offer(3);
        checks++;
        if (b_busy !== 1'b1) begin
            failures++;
            $display("FAIL overshoot_down_start got busy=%b expected 1", b_busy);
        end
        for (int i = 0; i < 2; i++) begin
            pe();
            checks++;
            if (b_load !== 1'b1 || b_ccr !== W'(dn_seq[i]) || b_done !== (i == 1)) begin
                failures++;
                $display("FAIL overshoot_down i=%0d got load=%b ccr=%0d done=%b expected 1 %0d %b",
                         i, b_load, b_ccr, b_done, dn_seq[i], (i == 1));
            end
        end
        pe();
        checks++;
        if (b_busy !== 1'b0 || b_ccr !== 3 || b_load !== 1'b0) begin
            failures++;
            $display("FAIL overshoot_final got busy=%b ccr=%0d load=%b expected 0 3 0", b_busy, b_ccr, b_load);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        offer(40);
        repeat (5) pe();
        tick();
        checks++;
        if (c_ccr !== 40 || c_busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_hold got ccr=%0d busy=%b expected 40 0", c_ccr, c_busy);
        end
        enable = 1'b0;
        #1;
        checks++;
        if (c_ready !== 1'b0) begin
            failures++;
            $display("FAIL drop_ready got %b expected 0", c_ready);
        end
        tick();
        checks++;
        if (c_busy !== 1'b1 || c_ccr !== 40) begin
            failures++;
            $display("FAIL drop_enter_down got busy=%b ccr=%0d expected 1 40", c_busy, c_ccr);
        end
        for (int i = 0; i < 5; i++) begin
            pe();
            checks++;
            if (c_load !== 1'b1 || c_ccr !== W'(32 - 8 * i) || c_done !== (i == 4)) begin
                failures++;
                $display("FAIL drop_step i=%0d got load=%b ccr=%0d done=%b expected 1 %0d %b",
                         i, c_load, c_ccr, c_done, 32 - 8 * i, (i == 4));
            end
        end
        tick();
        checks++;
        if (c_busy !== 1'b0 || c_ccr !== 0 || c_done !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle got busy=%b ccr=%0d done=%b expected 0 0 0", c_busy, c_ccr, c_done);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (c_ready !== 1'b1) begin
            failures++;
            $display("FAIL drop_ready_back got %b expected 1", c_ready);
        end
    endtask

    task automatic test_enable_rise();
        do_reset();
        offer(40);
        repeat (5) pe();
        tick();
        enable = 1'b0;
        tick();
        pe();
        checks++;
        if (c_ccr !== 32 || c_busy !== 1'b1) begin
            failures++;
            $display("FAIL rise_down got ccr=%0d busy=%b expected 32 1", c_ccr, c_busy);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (c_ccr !== 32 || c_busy !== 1'b1 || c_ready !== 1'b0) begin
            failures++;
            $display("FAIL rise_keep got ccr=%0d busy=%b ready=%b expected 32 1 0", c_ccr, c_busy, c_ready);
        end
        pe();
        checks++;
        if (c_ccr !== 40 || c_load !== 1'b1 || c_done !== 1'b1) begin
            failures++;
            $display("FAIL rise_up got ccr=%0d load=%b done=%b expected 40 1 1", c_ccr, c_load, c_done);
        end
    endtask

    task automatic test_handshake();
        int seq [5];
        seq = '{24, 32, 40, 48, 50};
        do_reset();
        offer(16);
        pe();
        tgt_valid = 1'b1;
        tgt_data  = 50;
        #1;
        checks++;
        if (c_ready !== 1'b0) begin
            failures++;
            $display("FAIL hs_ready_up got %b expected 0", c_ready);
        end
        tick();
        tgt_valid = 1'b0;
        pe();
        checks++;
        if (c_ccr !== 16 || c_done !== 1'b1) begin
            failures++;
            $display("FAIL hs_not_captured got ccr=%0d done=%b expected 16 1", c_ccr, c_done);
        end
        tick();
        tgt_valid = 1'b1;
        tgt_data  = 50;
        #1;
        checks++;
        if (c_ready !== 1'b1 || c_busy !== 1'b0) begin
            failures++;
            $display("FAIL hs_ready_hold got ready=%b busy=%b expected 1 0", c_ready, c_busy);
        end
        tick();
        tgt_valid = 1'b0;
        checks++;
        if (c_busy !== 1'b1 || c_ccr !== 16) begin
            failures++;
            $display("FAIL hs_captured got busy=%b ccr=%0d expected 1 16", c_busy, c_ccr);
        end
        for (int i = 0; i < 5; i++) begin
            pe();
            checks++;
            if (c_ccr !== W'(seq[i]) || c_done !== (i == 4)) begin
                failures++;
                $display("FAIL hs_ramp i=%0d got ccr=%0d done=%b expected %0d %b",
                         i, c_ccr, c_done, seq[i], (i == 4));
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        offer(40);
        repeat (5) pe();
        checks++;
        if (b_ccr !== 20 || b_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_ramp_pre got ccr=%0d busy=%b expected 20 1", b_ccr, b_busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_ccr !== 0 || b_busy !== 1'b0 || b_ready !== 1'b1 || b_load !== 1'b0) begin
            failures++;
            $display("FAIL mid_ramp_reset got ccr=%0d busy=%b ready=%b load=%b expected 0 0 1 0",
                     b_ccr, b_busy, b_ready, b_load);
        end
        tick();
        rst_n = 1'b1;
        pe();
        pe();
        checks++;
        if (b_ccr !== 0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_ramp_after got ccr=%0d busy=%b expected 0 0", b_ccr, b_busy);
        end
    endtask

    task automatic test_clamp();
        int  ceil_v;
        int  exp_steps;
        int  loads;
        int  peak;
        bit  seen;
`ifdef DUTY_CLAMP_EN
        ceil_v = 100;
`else
        ceil_v = 120;
`endif
        exp_steps = (ceil_v + 7) / 8;
        loads = 0;
        peak  = 0;
        seen  = 1'b0;
        do_reset();
        offer(120);
        for (int i = 0; i < 40 && !seen; i++) begin
            pe();
            if (c_load === 1'b1) loads++;
            if (int'(c_ccr) > peak) peak = int'(c_ccr);
            if (c_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || c_ccr !== W'(ceil_v)) begin
            failures++;
            $display("FAIL clamp_final got ccr=%0d done_seen=%b expected %0d 1", c_ccr, seen, ceil_v);
        end
        checks++;
        if (loads != exp_steps || peak != ceil_v) begin
            failures++;
            $display("FAIL clamp_steps got loads=%0d peak=%0d expected %0d %0d", loads, peak, exp_steps, ceil_v);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_no_overshoot();
        test_enable_drop();
        test_enable_rise();
        test_handshake();
        test_reset_mid_ramp();
        test_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/duty_ramp_ctrl.md
DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 7, duty/compare width matching the CCR width.
REQ-002 SHALL have parameter STEP, default 1, maximum duty change per step.
REQ-003 SHALL have parameter PERIODS_PER_STEP, default 1, count of PWM periods per step (1..255).
REQ-004 SHALL have parameter MAX_DUTY, default 100, duty ceiling used only under DUTY_CLAMP_EN.
REQ-005 SHALL have port CLK  input  1  single system clock, all logic on its rising edge.
REQ-006 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port PERIOD_END  input  1  one-CLK pulse from the timer block at counter overflow.
REQ-008 SHALL have port ENABLE  input  1  run request; low forces ramp-down to 0.
REQ-009 SHALL have port TGT_VALID  input  1  new target duty offered.
REQ-010 SHALL have port TGT_DATA  input  WIDTH  target duty value.
REQ-011 SHALL have port TGT_READY  output  1  target accept permitted.
REQ-012 SHALL have port CCR_VAL  output  WIDTH  duty value driven to the compare register.
REQ-013 SHALL have port CCR_LOAD  output  1  one-cycle strobe, CCR_VAL changed this cycle.
REQ-014 SHALL have port BUSY  output  1  high while in UP or DOWN.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse when CCR_VAL reaches the effective target.

Function
REQ-016 SHALL implement states IDLE, UP, DOWN, HOLD.
REQ-017 SHALL drive TGT_READY = ENABLE and (state is IDLE or HOLD), combinationally.
REQ-018 SHALL capture TGT_DATA into the target register on a CLK edge with TGT_VALID and TGT_READY high, and clear the period prescaler on that edge.
REQ-019 SHALL set effective target = captured target when ENABLE=1, else 0.
REQ-020 SHALL, in IDLE/HOLD, go to UP if effective target > CCR_VAL, DOWN if less, otherwise stay.
REQ-021 SHALL, on capture of a target equal to CCR_VAL, enter HOLD and pulse DONE on the following cycle.
REQ-022 SHALL advance the prescaler only on PERIOD_END in UP/DOWN; a step occurs on the PERIOD_END where the prescaler equals PERIODS_PER_STEP-1, which also wraps the prescaler to 0.
REQ-023 SHALL, on a step, move CCR_VAL toward the effective target by min(STEP, |target - CCR_VAL|), never overshooting and never wrapping past 0 or 2^WIDTH-1.
REQ-024 SHALL register CCR_VAL and CCR_LOAD on the same edge as the step, so CCR_LOAD=1 for exactly that one cycle with the new value.
REQ-025 SHALL, when a step makes CCR_VAL equal the target, move to HOLD (or IDLE if target is 0) on the same edge and assert DONE for one cycle on that edge.
REQ-026 SHALL, when ENABLE falls in any state with CCR_VAL > 0, go to DOWN on the next edge; with CCR_VAL = 0, go to IDLE.
REQ-027 SHALL, when ENABLE rises during DOWN, re-evaluate direction against the captured target on the next edge without losing the current CCR_VAL.
REQ-028 SHALL ignore PERIOD_END in IDLE and HOLD (no CCR_LOAD).
REQ-029 SHALL ignore TGT_VALID while TGT_READY=0; no queuing.

Reset
REQ-030 SHALL, while RST_N=0, force state IDLE, CCR_VAL=0, target=0, prescaler=0, CCR_LOAD=0, DONE=0, BUSY=0, regardless of CLK.
REQ-031 SHALL, on reset asserted mid-ramp, abandon the ramp and resume from IDLE with CCR_VAL=0 after release.

Configuration
REQ-032 SHALL, with macro DUTY_CLAMP_EN defined, clamp captured targets above MAX_DUTY to MAX_DUTY.
REQ-033 SHALL, without DUTY_CLAMP_EN, capture TGT_DATA unmodified and omit MAX_DUTY logic.

Verification
REQ-034 Reset mid-ramp: RST_N low while CCR_VAL=20 in UP -> CCR_VAL=0, BUSY=0, TGT_READY=1 immediately, no CLK needed.
REQ-035 Ramp up: STEP=1, PERIODS_PER_STEP=2, target 5 from 0 -> CCR_LOAD on every 2nd PERIOD_END, values 1..5, DONE once on value 5, state HOLD.
REQ-036 No overshoot: STEP=4, CCR_VAL=10, target 3 -> values 6, 3, then DONE; 3 is never undershot.
REQ-037 Enable drop: HOLD at 40, ENABLE=0, STEP=8 -> TGT_READY=0, values 32,24,16,8,0, final state IDLE, DONE on 0.
REQ-038 Handshake: TGT_VALID=1 with TGT_DATA=50 during UP -> not captured; same offer in HOLD -> captured on that edge, BUSY=1 next cycle.
REQ-039 Clamp: DUTY_CLAMP_EN defined, MAX_DUTY=100, target 120 -> ramp stops at 100; undefined -> ramp stops at 120.
